// File: rtl/lm32_logic_unit_pkg.sv
// lm32_logic_unit_pkg
//   Shared encodings for the multi-mode logic unit: operation modes, common
//   truth-table opcodes and the reduction FSM states.
package lm32_logic_unit_pkg;

  // Mode 3 is reserved and behaves as BITWISE.
  typedef enum logic [1:0] {
    LM32_LOGIC_MODE_BITWISE = 2'd0,
    LM32_LOGIC_MODE_POPCNT  = 2'd1,
    LM32_LOGIC_MODE_CLZ     = 2'd2,
    LM32_LOGIC_MODE_RSVD    = 2'd3
  } logic_mode_e;

  // Truth tables indexed by {operand_1[i], operand_0[i]}.
  localparam logic [3:0] LM32_LOGIC_OP_AND = 4'b1000;
  localparam logic [3:0] LM32_LOGIC_OP_OR  = 4'b1110;
  localparam logic [3:0] LM32_LOGIC_OP_XOR = 4'b0110;
  localparam logic [3:0] LM32_LOGIC_OP_NOR = 4'b0001;
  localparam logic [3:0] LM32_LOGIC_OP_A   = 4'b1010;

  typedef enum logic {
    LM32_LOGIC_ST_IDLE  = 1'b0,
    LM32_LOGIC_ST_COUNT = 1'b1
  } logic_state_e;

endpackage

// File: rtl/lm32_logic_unit_tt.sv
// lm32_logic_tt
//   Combinational WIDTH-bit truth-table slice: result[i] is the entry of
//   logic_op selected by {operand_1[i], operand_0[i]}.
// Ports:
//   logic_op   4-bit truth table
//   operand_0  operand A
//   operand_1  operand B
//   result     bitwise result T
module lm32_logic_tt #(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       logic_op,
  input  logic [WIDTH-1:0] operand_0,
  input  logic [WIDTH-1:0] operand_1,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      result[i] = logic_op[{operand_1[i], operand_0[i]}];
    end
  end

endmodule

// File: rtl/lm32_logic_unit.sv
// lm32_logic_unit
//   X-stage logic unit. Applies a 4-bit truth table bitwise over two
//   WIDTH-bit operands, then either registers the result (BITWISE) or
//   reduces it CHUNK bits per cycle to a population count or a
//   leading-zero count.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   valid_x           operation request
//   mode_x            0 BITWISE, 1 POPCNT, 2 CLZ, 3 treated as BITWISE
//   logic_op_x        truth table
//   operand_0_x/1_x   operands A/B
//   stall_x           freeze all state, block acceptance
//   kill_x            abort reduction, block acceptance (overrides stall)
//   busy_x            reduction in progress
//   result_m          registered result, counts zero-extended
//   result_valid_m    one-cycle pulse when result_m is new
module lm32_logic_unit
  import lm32_logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_x,
  input  logic [1:0]       mode_x,
  input  logic [3:0]       logic_op_x,
  input  logic [WIDTH-1:0] operand_0_x,
  input  logic [WIDTH-1:0] operand_1_x,
  input  logic             stall_x,
  input  logic             kill_x,
  output logic             busy_x,
  output logic [WIDTH-1:0] result_m,
  output logic             result_valid_m
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNTW   = $clog2(WIDTH) + 1;  // holds WIDTH itself
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CSHIFT = $clog2(CHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  function automatic logic [CNTW-1:0] chunk_popcount(input logic [CHUNK-1:0] c);
    logic [CNTW-1:0] n;
    n = '0;
    for (int i = 0; i < CHUNK; i++) n = n + CNTW'(c[i]);
    return n;
  endfunction

  function automatic logic [CNTW-1:0] chunk_lz(input logic [CHUNK-1:0] c);
    logic [CNTW-1:0] n;
    logic            seen;
    n    = '0;
    seen = 1'b0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      seen = seen | c[i];
      if (!seen) n = n + CNTW'(1);
    end
    return n;
  endfunction

  logic_state_e     state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [CNTW-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             clz_q, clz_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;

  logic [WIDTH-1:0] tt_result;
  logic_mode_e      mode;
  logic             accept;
  logic             count_mode;
  logic [CNTW-1:0]  shamt;
  logic [CHUNK-1:0] pop_chunk;
  logic [CHUNK-1:0] lz_chunk;
  logic [CNTW-1:0]  step_sum;
  logic             step_done;

  lm32_logic_tt #(.WIDTH(WIDTH)) u_tt (
    .logic_op  (logic_op_x),
    .operand_0 (operand_0_x),
    .operand_1 (operand_1_x),
    .result    (tt_result)
  );

  assign mode       = logic_mode_e'(mode_x);
  assign count_mode = (mode == LM32_LOGIC_MODE_POPCNT) || (mode == LM32_LOGIC_MODE_CLZ);
  assign busy_x     = (state_q == LM32_LOGIC_ST_COUNT);
  assign accept     = valid_x && !busy_x && !stall_x && !kill_x;

  // Chunk idx sits idx*CHUNK bits from the LSB for POPCNT and from the MSB
  // for CLZ; shifting the shadow aligns it instead of a variable part-select.
  assign shamt     = CNTW'(idx_q) << CSHIFT;
  assign pop_chunk = CHUNK'(shadow_q >> shamt);
  assign lz_chunk  = CHUNK'((shadow_q << shamt) >> (WIDTH - CHUNK));

  // One reduction step: the running count after this chunk, and whether
  // the operation completes this cycle (last chunk, or CLZ hit a set bit).
  always_comb begin
    step_sum  = acc_q + chunk_popcount(pop_chunk);
    step_done = (idx_q == LAST_IDX);
    if (clz_q) begin
      if (lz_chunk == '0) begin
        step_sum = acc_q + CNTW'(CHUNK);
      end else begin
        step_sum  = acc_q + chunk_lz(lz_chunk);
        step_done = 1'b1;
      end
    end
  end

  // NOTE: every _d gets a hold/default value first so no path through the
  // branches leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    acc_d          = acc_q;
    shadow_d       = shadow_q;
    clz_d          = clz_q;
    result_d       = result_q;
    result_valid_d = 1'b0;

    if (kill_x) begin
      // Abort wins over stall; result_m keeps its previous value.
      state_d = LM32_LOGIC_ST_IDLE;
    end else if (stall_x) begin
      // Hold everything; a completion due now is deferred.
    end else if (busy_x) begin
      if (step_done) begin
        result_d       = WIDTH'(step_sum);
        result_valid_d = 1'b1;
        state_d        = LM32_LOGIC_ST_IDLE;
      end else begin
        acc_d = step_sum;
        idx_d = idx_q + IDXW'(1);
      end
    end else if (accept) begin
      if (count_mode) begin
        shadow_d = tt_result;
        acc_d    = '0;
        idx_d    = '0;
        clz_d    = (mode == LM32_LOGIC_MODE_CLZ);
        state_d  = LM32_LOGIC_ST_COUNT;
      end else begin
        result_d       = tt_result;
        result_valid_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values. The shadow is reset too, so a reset mid-reduction
  // leaves no stale operand behind.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= LM32_LOGIC_ST_IDLE;
      idx_q          <= '0;
      acc_q          <= '0;
      shadow_q       <= '0;
      clz_q          <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      acc_q          <= acc_d;
      shadow_q       <= shadow_d;
      clz_q          <= clz_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign result_m       = result_q;
  assign result_valid_m = result_valid_q;

endmodule
